sprite_line_engine: RTL
=======================

Name: sprite_line_engine

Overview:
- Consumer end of the CPU sprite-register write interface: the sprite_sel, sprite_x, sprite_y, sprite_attr, sprite_pos and sprite_vis outputs of the pipeline datapath.
- Holds a 32-entry sprite attribute table written by the CPU.
- During each horizontal blank, scans the table for the upcoming scanline and latches up to MAX_PER_LINE candidate sprites.
- During active video, reports per pixel whether a sprite covers it, which sprite, and the texel offset, so the VGA pixel mux can address the sprite ROM.

Parameters:
- NUM_SPR, 32, table entries; index width is 5 and fixed.
- SPR_DIM, 16, sprite width and height in pixels; must be a power of two.
- MAX_PER_LINE, 4, candidate slots per scanline.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sprite_sel  in  5  table index for a CPU write
- sprite_x  in  10  X position data
- sprite_y  in  9  Y position data
- sprite_pos  in  1  strobe: write sprite_x and sprite_y into entry sprite_sel
- sprite_vis  in  1  strobe: write the visible bit of entry sprite_sel
- sprite_attr  in  1  visible-bit value written when sprite_vis=1
- line_start  in  1  one-cycle pulse at the start of hblank
- scan_line  in  9  scanline to prepare; sampled on line_start
- hcount  in  10  current active-video pixel column
- pix_hit  out  1  a sprite covers the current pixel
- pix_sprite  out  5  index of the winning sprite
- pix_col  out  4  hcount minus the sprite's X position
- pix_row  out  4  scan_line minus the sprite's Y position
- spr_overflow  out  1  more than MAX_PER_LINE sprites matched the prepared line
- scan_busy  out  1  a table scan is in progress

Behaviour:
- Reset:
  - All table entries cleared: x=0, y=0, vis=0.
  - Pending and active slots invalid.
  - FSM in IDLE.
  - All outputs 0.
- CPU writes:
  - Take effect at the clock edge.
  - sprite_pos and sprite_vis may both be asserted in one cycle; both writes apply.
  - Writes are accepted in every FSM state.
  - A scan reads the table value present in the cycle it visits that entry; no shadowing.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - On line_start: latch scan_line into line_q, clear the pending slots, clear spr_overflow, set idx=0, go to SCAN.
- SCAN (one entry per cycle, idx 0 to 31):
  - Match condition: vis=1 AND d=line_q-y, computed 10-bit unsigned with a zero-extended line and no wrap, satisfies d<SPR_DIM.
  - On a match with a free slot: fill the next slot with {idx, x, d[3:0]}.
  - On a match with all slots full: set spr_overflow=1.
  - At idx=31: go to COMMIT.
  - Total scan length is 32 cycles.
- COMMIT (one cycle):
  - Copy the pending slots to the active slots.
  - Go to IDLE.
- Latency: line_start to new active slots is 34 cycles. hblank must be at least 40 cycles.
- line_start during SCAN or COMMIT: abort, restart from idx=0 with the new scan_line. No commit for the aborted line; active slots are unchanged.
- scan_busy=1 in SCAN and COMMIT.
- Pixel path, per active slot:
  - Hit when e=hcount-x, computed 11-bit unsigned, satisfies e<SPR_DIM.
  - Priority goes to the lowest slot number, which is also the lowest sprite index because slots fill in index order.
  - Outputs are registered: one-cycle latency from hcount.
  - On no hit: pix_hit=0 and pix_sprite, pix_col, pix_row = 0.
- Edges:
  - x=1020 covers columns 1020..1023 only; no wrap to column 0.
  - y=500 never matches lines 0..15.
- spr_overflow: sticky from the first excess match until the next line_start. Excess sprites are dropped.

Decomposition:
- Package sprite_pkg holds:
  - Constants NUM_SPR, SPR_DIM, MAX_PER_LINE, IDX_W=5.
  - FSM state encoding: IDLE=2'd0, SCAN=2'd1, COMMIT=2'd2.
  - Slot field widths.
- One sub-module, sprite_slot_cmp: per-slot horizontal compare. Inputs are the slot valid flag, x and hcount; outputs are hit and col. It is instantiated MAX_PER_LINE times and feeds the priority encoder.

Test Plan:
- Position and visibility:
  - Stimulus: write sprite 3 with x=100, y=50, vis=1; line_start with scan_line=55; wait 34 cycles; sweep hcount.
  - Expected: at hcount 100, pix_hit=1, sprite=3, col=0, row=5. At 115, col=15. At 116 and at 99, pix_hit=0. All outputs one cycle after hcount.
- Overlap priority:
  - Stimulus: sprites 2 and 7 both at x=200, y=10; scan line 12.
  - Expected: hcount 205 gives pix_sprite=2, col=5, row=2.
- Overflow:
  - Stimulus: sprites 0..5 visible, y=20, x=16·i; scan line 20.
  - Expected: sprites 0..3 produce hits. hcount 70 (sprite 4) gives pix_hit=0. spr_overflow=1 until the next line_start.
- Visibility and vertical edges:
  - Stimulus: sprite 9 with vis=0, then y=500 with vis=1.
  - Expected: vis=0 never hits. With y=500: line 3 no hit, line 510 hit with row=10.
- Abort and commit:
  - Stimulus: line_start(40), then a second line_start(60) at scan cycle 10, with sprite 1 at y=40 only.
  - Expected: no commit for line 40. After 34 more cycles, active slots are empty for line 60.
- Mid-operation reset:
  - Stimulus: assert reset during SCAN.
  - Expected: next cycle scan_busy=0, pix_hit=0, table cleared. A subsequent scan finds no sprites.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and slot record for the sprite line engine.
package sprite_pkg;
  localparam int unsigned NUM_SPR      = 32;
  localparam int unsigned SPR_DIM      = 16;
  localparam int unsigned MAX_PER_LINE = 4;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 9;
  localparam int unsigned DIM_W        = $clog2(SPR_DIM);
  localparam int unsigned SLOT_W       = $clog2(MAX_PER_LINE);
  localparam int unsigned CNT_W        = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [X_W-1:0]   x;
    logic [DIM_W-1:0] row;
  } slot_t;
endpackage

// File: rtl/sprite_slot_cmp.sv
// Horizontal coverage test for one active slot against the current pixel column.
module sprite_slot_cmp
  import sprite_pkg::*;
(
  input  logic             valid,
  input  logic [X_W-1:0]   x,
  input  logic [X_W-1:0]   hcount,
  output logic             hit,
  output logic [DIM_W-1:0] col
);
  logic [X_W:0] e;

  // One extra bit so columns left of x land far above SPR_DIM instead of wrapping.
  assign e   = {1'b0, hcount} - {1'b0, x};
  assign hit = valid && (e < (X_W+1)'(SPR_DIM));
  assign col = e[DIM_W-1:0];
endmodule

// File: rtl/sprite_line_engine.sv
// Sprite attribute table, hblank candidate scan and registered per-pixel hit lookup.
//   state  | meaning
//   IDLE   | waiting for line_start
//   SCAN   | visiting one table entry per cycle, filling pending slots
//   COMMIT | pending slots copied to active slots
module sprite_line_engine
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] sprite_sel,
  input  logic [X_W-1:0]   sprite_x,
  input  logic [Y_W-1:0]   sprite_y,
  input  logic             sprite_pos,
  input  logic             sprite_vis,
  input  logic             sprite_attr,
  input  logic             line_start,
  input  logic [Y_W-1:0]   scan_line,
  input  logic [X_W-1:0]   hcount,
  output logic             pix_hit,
  output logic [IDX_W-1:0] pix_sprite,
  output logic [DIM_W-1:0] pix_col,
  output logic [DIM_W-1:0] pix_row,
  output logic             spr_overflow,
  output logic             scan_busy
);
  logic [X_W-1:0]     tbl_x [NUM_SPR];
  logic [Y_W-1:0]     tbl_y [NUM_SPR];
  logic [NUM_SPR-1:0] tbl_vis;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        tbl_x[i] <= '0;
        tbl_y[i] <= '0;
      end
      tbl_vis <= '0;
    end else begin
      if (sprite_pos) begin
        tbl_x[sprite_sel] <= sprite_x;
        tbl_y[sprite_sel] <= sprite_y;
      end
      if (sprite_vis) tbl_vis[sprite_sel] <= sprite_attr;
    end
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [Y_W-1:0]   line_q;
  logic [CNT_W-1:0] pend_cnt;
  slot_t            pend [MAX_PER_LINE];
  slot_t            act  [MAX_PER_LINE];
  logic [X_W-1:0]   d;
  logic             match;

  // Entries below the line give a large d because line and y are zero-extended.
  assign d     = {1'b0, line_q} - {1'b0, tbl_y[idx]};
  assign match = tbl_vis[idx] && (d < X_W'(SPR_DIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      line_q       <= '0;
      pend_cnt     <= '0;
      spr_overflow <= 1'b0;
      scan_busy    <= 1'b0;
      for (int s = 0; s < MAX_PER_LINE; s++) begin
        pend[s] <= '0;
        act[s]  <= '0;
      end
    end else if (line_start) begin
      // A new line_start always wins, aborting any scan or commit in flight.
      state        <= SCAN;
      idx          <= '0;
      line_q       <= scan_line;
      pend_cnt     <= '0;
      spr_overflow <= 1'b0;
      scan_busy    <= 1'b1;
      for (int s = 0; s < MAX_PER_LINE; s++) pend[s] <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (match) begin
            if (pend_cnt < CNT_W'(MAX_PER_LINE)) begin
              pend[pend_cnt[SLOT_W-1:0]] <= '{valid: 1'b1, idx: idx, x: tbl_x[idx],
                                             row: d[DIM_W-1:0]};
              pend_cnt <= pend_cnt + 1'b1;
            end else begin
              spr_overflow <= 1'b1;
            end
          end
          if (idx == IDX_W'(NUM_SPR - 1)) state <= COMMIT;
          idx <= idx + 1'b1;
        end
        COMMIT: begin
          for (int s = 0; s < MAX_PER_LINE; s++) act[s] <= pend[s];
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

  logic [MAX_PER_LINE-1:0] slot_hit;
  logic [DIM_W-1:0]        slot_col [MAX_PER_LINE];

  for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_cmp
    sprite_slot_cmp u_cmp (
      .valid  (act[s].valid),
      .x      (act[s].x),
      .hcount (hcount),
      .hit    (slot_hit[s]),
      .col    (slot_col[s])
    );
  end

  logic             win_hit;
  logic [IDX_W-1:0] win_sprite;
  logic [DIM_W-1:0] win_col;
  logic [DIM_W-1:0] win_row;

  // Walk from the highest slot down so the lowest matching slot is the last writer.
  always_comb begin
    win_hit    = 1'b0;
    win_sprite = '0;
    win_col    = '0;
    win_row    = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        win_hit    = 1'b1;
        win_sprite = act[s].idx;
        win_col    = slot_col[s];
        win_row    = act[s].row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_hit    <= 1'b0;
      pix_sprite <= '0;
      pix_col    <= '0;
      pix_row    <= '0;
    end else begin
      pix_hit    <= win_hit;
      pix_sprite <= win_sprite;
      pix_col    <= win_col;
      pix_row    <= win_row;
    end
  end
endmodule
